irq_controller: RTL and testbench
=================================

# irq_controller

Machine-mode trap sequencer that drives the trap side of the CSR controller. It arbitrates external interrupt lines and synchronous exceptions, then issues a one-cycle trap pulse with the matching mcause and redirects the PC to mtvec. It tracks the handler until mret, then redirects to mepc and acknowledges the serviced interrupt line. It sits between the interrupt sources and pipeline on one side and the CSR controller's trap_i/mcause_i and mie/mtvec/mepc outputs on the other.

## Interface
- IRQ_NUM, 16, number of interrupt lines; legal range 1..16.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- irq_req_i  input  IRQ_NUM  level-sensitive interrupt requests; line k holds until acknowledged.
- mie_i  input  32  interrupt mask from the CSR controller; bit 16+k enables line k.
- mtvec_i  input  32  trap vector from the CSR controller.
- mepc_i  input  32  return PC from the CSR controller.
- exception_i  input  1  synchronous exception from the pipeline, valid this cycle.
- exception_cause_i  input  32  cause code for exception_i; bit 31 is 0.
- mret_i  input  1  mret retiring this cycle.
- stall_i  input  1  pipeline stalled; blocks interrupt entry only.
- trap_o  output  1  one-cycle pulse; connects to trap_i.
- mcause_o  output  32  cause of the current or last trap; connects to mcause_i.
- pc_redirect_o  output  1  PC override valid this cycle.
- redirect_pc_o  output  32  PC override value.
- irq_ret_o  output  IRQ_NUM  one-hot, one-cycle acknowledge of the serviced line.
- busy_o  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, TRAP, HANDLER, RET. Registers: state, mcause, src (one-hot, IRQ_NUM bits), ack_mask (IRQ_NUM bits).
- Pending vector: pend = irq_req_i & mie_i[16 +: IRQ_NUM] & ~ack_mask.
- IDLE transitions:
  - exception_i=1: go to TRAP, mcause <= exception_cause_i, src unchanged. This ignores stall_i and has priority over interrupts.
  - Otherwise, if stall_i=0 and pend≠0: go to TRAP. k is the lowest set index of pend. mcause <= 32'h8000_0010 + k, src <= 1<<k.
  - mret_i is ignored in IDLE: no redirect, no ack.
- TRAP: trap_o=1, pc_redirect_o=1, redirect_pc_o=mtvec_i. Go to HANDLER unconditionally.
- HANDLER: interrupts are ignored (no nesting).
  - exception_i=1: go to TRAP with the new cause; src is retained.
  - Else mret_i=1: go to RET.
  - exception_i and mret_i in the same cycle: the exception wins.
- RET: pc_redirect_o=1, redirect_pc_o=mepc_i, irq_ret_o=src. Then src <= 0, ack_mask <= src, go to IDLE.
  - If src=0 (exception-only trap), irq_ret_o stays 0.
- ack_mask is nonzero only in the single IDLE cycle after RET; it is cleared on every other edge. A source must drop its request within one cycle of the ack or it is retaken.
- Outputs outside TRAP/RET: trap_o=0, pc_redirect_o=0, redirect_pc_o=0, irq_ret_o=0.
- mcause_o reflects the mcause register directly and holds its value until the next trap.

## Timing
- Reset (rst_ni=0 at an edge): state=IDLE, mcause=0, src=0, ack_mask=0. Every output is 0.
- Reset mid-handler abandons the trap: no irq_ret_o pulse and no redirect.
- Interrupt latency: pend sampled nonzero in IDLE at edge N, so trap_o is high in cycle N+1. The pipeline presents the interrupted PC on the CSR controller's pc_i in that cycle.
- mret latency: mret_i at edge M, so the RET cycle (redirect to mepc, ack) is cycle M+1. IDLE is reached at M+2.
- mcause_o is valid in the same cycle as trap_o, so the CSR controller captures mepc and mcause on the same edge.
- Back-to-back: the earliest re-entry is a TRAP cycle at M+3 (IDLE at M+2, TRAP at M+3).
- State, mcause, src and ack_mask are registered. trap_o, pc_redirect_o, redirect_pc_o, irq_ret_o and busy_o are decoded from state and registers only; they have no combinational path from irq_req_i or exception_i.

## Test plan
- Reset then single IRQ: mie_i=32'h0004_0000, irq_req_i[2] raised. Required: trap_o one cycle later, mcause_o=32'h8000_0012, redirect_pc_o=mtvec_i. Then mret_i gives redirect_pc_o=mepc_i and irq_ret_o=16'h0004 for one cycle.
- Priority and masking: irq_req_i=16'h00C1 with mie_i=32'h00C0_0000. Required: line 6 taken (mcause 32'h8000_0016); line 0 never taken.
- Exception vs interrupt: exception_i with cause 32'h2 in the same cycle as an enabled irq. Required: mcause_o=2 and src=0, so mret produces no irq_ret_o. The interrupt is taken after IDLE.
- Nested exception in HANDLER for IRQ 3: a second TRAP pulse with the exception cause. The following mret acks line 3. Simultaneous mret_i+exception_i traps.
- Stall: stall_i=1 holds an enabled irq off indefinitely, while exception_i is still taken. Releasing stall_i gives trap_o the next cycle.
- Reset in HANDLER: rst_ni=0 for one edge. Required: all outputs 0, busy_o=0, no irq_ret_o. A held irq retraps two cycles after release.

Source files
------------

// File: rtl/irq_controller_if.sv
// Signal bundle between the trap sequencer and its surroundings (interrupt
// sources, pipeline, CSR controller). master = irq_controller, slave = environment.
interface irq_controller_if #(
    parameter int IRQ_NUM = 16
);
    logic [IRQ_NUM-1:0] irq_req_i;
    logic [31:0]        mie_i;
    logic [31:0]        mtvec_i;
    logic [31:0]        mepc_i;
    logic               exception_i;
    logic [31:0]        exception_cause_i;
    logic               mret_i;
    logic               stall_i;
    logic               trap_o;
    logic [31:0]        mcause_o;
    logic               pc_redirect_o;
    logic [31:0]        redirect_pc_o;
    logic [IRQ_NUM-1:0] irq_ret_o;
    logic               busy_o;
    logic [1:0]         state_dbg;

    // No valid/ready pairs here: trap_o and irq_ret_o are single-cycle pulses
    // that the receiver must consume in the cycle they are high.
    modport master (
        input  irq_req_i, mie_i, mtvec_i, mepc_i, exception_i, exception_cause_i,
               mret_i, stall_i,
        output trap_o, mcause_o, pc_redirect_o, redirect_pc_o, irq_ret_o, busy_o,
               state_dbg
    );

    modport slave (
        output irq_req_i, mie_i, mtvec_i, mepc_i, exception_i, exception_cause_i,
               mret_i, stall_i,
        input  trap_o, mcause_o, pc_redirect_o, redirect_pc_o, irq_ret_o, busy_o,
               state_dbg
    );
endinterface

// File: rtl/irq_controller.sv
// Machine-mode trap sequencer: arbitrates interrupts and exceptions, pulses trap,
// redirects to mtvec, and on mret redirects to mepc and acks the serviced line.
module irq_controller #(
    parameter int IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    irq_controller_if.master   bus
);
    typedef enum logic [1:0] {IDLE, TRAP, HANDLER, RET} state_t;

    state_t             state_q, state_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [IRQ_NUM-1:0] src_q, src_d;
    logic [IRQ_NUM-1:0] ack_mask_q, ack_mask_d;
    logic [IRQ_NUM-1:0] pend;
    logic [4:0]         irq_idx;
    logic               unused_ok;

    // Low mie bits are not interrupt enables for this block.
    assign unused_ok = &{1'b0, bus.mie_i};

    // ack_mask hides the just-acknowledged line for one IDLE cycle so the
    // source has time to drop its level request.
    assign pend = bus.irq_req_i & bus.mie_i[16 +: IRQ_NUM] & ~ack_mask_q;

    always_comb begin
        irq_idx = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[i]) irq_idx = 5'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mcause_q   <= '0;
            src_q      <= '0;
            ack_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            mcause_q   <= mcause_d;
            src_q      <= src_d;
            ack_mask_q <= ack_mask_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mcause_d   = mcause_q;
        src_d      = src_q;
        ack_mask_d = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.exception_i) begin
                    state_d  = TRAP;
                    mcause_d = bus.exception_cause_i;
                end else if (!bus.stall_i && (pend != '0)) begin
                    state_d  = TRAP;
                    mcause_d = 32'h8000_0010 + {27'b0, irq_idx};
                    src_d    = {{(IRQ_NUM-1){1'b0}}, 1'b1} << irq_idx;
                end
            end
            TRAP: state_d = HANDLER;
            HANDLER: begin
                // No nesting of interrupts; an exception re-traps and keeps src.
                if (bus.exception_i) begin
                    state_d  = TRAP;
                    mcause_d = bus.exception_cause_i;
                end else if (bus.mret_i) begin
                    state_d = RET;
                end
            end
            RET: begin
                state_d    = IDLE;
                src_d      = '0;
                ack_mask_d = src_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        bus.trap_o        = 1'b0;
        bus.pc_redirect_o = 1'b0;
        bus.redirect_pc_o = '0;
        bus.irq_ret_o     = '0;
        if (state_q == TRAP) begin
            bus.trap_o        = 1'b1;
            bus.pc_redirect_o = 1'b1;
            bus.redirect_pc_o = bus.mtvec_i;
        end else if (state_q == RET) begin
            bus.pc_redirect_o = 1'b1;
            bus.redirect_pc_o = bus.mepc_i;
            bus.irq_ret_o     = src_q;
        end
    end

    assign bus.mcause_o  = mcause_q;
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: linear steps with hand-computed expectations.
module tb_irq_controller;
    localparam int IRQ_NUM = 16;
    localparam logic [31:0] MTVEC = 32'h0000_1000;
    localparam logic [31:0] MEPC  = 32'h0000_2000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    irq_controller_if #(.IRQ_NUM(IRQ_NUM)) bus ();

    irq_controller #(.IRQ_NUM(IRQ_NUM)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".trap"},  32'(bus.trap_o), 32'h0);
        chk({tag, ".redir"}, 32'(bus.pc_redirect_o), 32'h0);
        chk({tag, ".pc"},    bus.redirect_pc_o, 32'h0);
        chk({tag, ".ret"},   32'(bus.irq_ret_o), 32'h0);
        chk({tag, ".busy"},  32'(bus.busy_o), 32'h0);
    endtask

    task automatic chk_trap(input string tag, input logic [31:0] cause);
        chk({tag, ".trap"},   32'(bus.trap_o), 32'h1);
        chk({tag, ".redir"},  32'(bus.pc_redirect_o), 32'h1);
        chk({tag, ".pc"},     bus.redirect_pc_o, MTVEC);
        chk({tag, ".mcause"}, bus.mcause_o, cause);
        chk({tag, ".busy"},   32'(bus.busy_o), 32'h1);
    endtask

    task automatic chk_ret(input string tag, input logic [15:0] ack);
        chk({tag, ".trap"},  32'(bus.trap_o), 32'h0);
        chk({tag, ".redir"}, 32'(bus.pc_redirect_o), 32'h1);
        chk({tag, ".pc"},    bus.redirect_pc_o, MEPC);
        chk({tag, ".ret"},   32'(bus.irq_ret_o), 32'(ack));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.irq_req_i = '0;
        bus.mie_i = '0;
        bus.mtvec_i = MTVEC;
        bus.mepc_i = MEPC;
        bus.exception_i = 1'b0;
        bus.exception_cause_i = '0;
        bus.mret_i = 1'b0;
        bus.stall_i = 1'b0;

        // Reset state
        step();
        step();
        chk_idle("rst");
        chk("rst.mcause", bus.mcause_o, 32'h0);
        chk("rst.state", 32'(bus.state_dbg), 32'h0);

        // Single IRQ on line 2
        rst_n = 1'b1;
        bus.mie_i = 32'h0004_0000;
        bus.irq_req_i = 16'h0004;
        step();
        chk_trap("irq2", 32'h8000_0012);
        step();
        chk("irq2.hdl.trap", 32'(bus.trap_o), 32'h0);
        chk("irq2.hdl.redir", 32'(bus.pc_redirect_o), 32'h0);
        chk("irq2.hdl.busy", 32'(bus.busy_o), 32'h1);
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("irq2.ret", 16'h0004);
        bus.irq_req_i = '0;
        step();
        chk_idle("irq2.idle");
        chk("irq2.mcause_hold", bus.mcause_o, 32'h8000_0012);

        // Priority and masking: lines 0,6,7 requested, only 6 and 7 enabled
        bus.mie_i = 32'h00C0_0000;
        bus.irq_req_i = 16'h00C1;
        step();
        chk_trap("prio6", 32'h8000_0016);
        step();
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("prio6.ret", 16'h0040);
        bus.irq_req_i = 16'h0081;
        step();
        chk_idle("prio.gap");
        step();
        chk_trap("prio7", 32'h8000_0017);
        step();
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("prio7.ret", 16'h0080);
        bus.irq_req_i = 16'h0001;
        step();
        step();
        chk_idle("line0.masked");
        bus.irq_req_i = '0;

        // Exception beats a simultaneous enabled interrupt
        bus.mie_i = 32'h0008_0000;
        bus.irq_req_i = 16'h0008;
        bus.exception_i = 1'b1;
        bus.exception_cause_i = 32'h2;
        step();
        bus.exception_i = 1'b0;
        chk_trap("exc", 32'h0000_0002);
        step();
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("exc.ret", 16'h0000);
        step();
        chk_idle("exc.idle");
        step();
        chk_trap("irq3", 32'h8000_0013);

        // Nested exception inside the IRQ 3 handler, then mret+exception together
        step();
        bus.exception_i = 1'b1;
        bus.exception_cause_i = 32'h5;
        step();
        bus.exception_i = 1'b0;
        chk_trap("nest5", 32'h0000_0005);
        step();
        bus.exception_i = 1'b1;
        bus.mret_i = 1'b1;
        bus.exception_cause_i = 32'h7;
        step();
        bus.exception_i = 1'b0;
        bus.mret_i = 1'b0;
        chk_trap("nest7", 32'h0000_0007);
        step();
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("nest.ret", 16'h0008);
        bus.irq_req_i = '0;
        step();
        chk_idle("nest.idle");

        // Stall holds the interrupt off but not an exception
        bus.stall_i = 1'b1;
        bus.irq_req_i = 16'h0008;
        step();
        step();
        step();
        chk_idle("stall.hold");
        bus.exception_i = 1'b1;
        bus.exception_cause_i = 32'h4;
        step();
        bus.exception_i = 1'b0;
        chk_trap("stall.exc", 32'h0000_0004);
        step();
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("stall.ret", 16'h0000);
        step();
        step();
        chk_idle("stall.hold2");
        bus.stall_i = 1'b0;
        step();
        chk_trap("stall.rel", 32'h8000_0013);

        // Reset in HANDLER abandons the trap
        step();
        chk("rsth.busy", 32'(bus.busy_o), 32'h1);
        rst_n = 1'b0;
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_idle("rsth");
        chk("rsth.mcause", bus.mcause_o, 32'h0);
        rst_n = 1'b1;
        step();
        chk_trap("rsth.retrap", 32'h8000_0013);
        step();
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        chk_ret("rsth.ret", 16'h0008);
        bus.irq_req_i = '0;
        step();
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
